// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the RISC-V core, feeding `decoder`.
//
// Holds the program counter and keeps at most one 32-bit instruction-memory
// request in flight. Each returned word is presented with its PC to `decoder`
// through a valid/ready handshake. A one-entry skid register absorbs a
// response that arrives while the decoder is stalled. Redirects from execute
// flush buffered words and discard the in-flight response.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   -> a redirect to a non-word-aligned target parks the stage in
//                FAULT with fetchFault=1 until an aligned redirect or reset.
//   undefined -> the low two target bits are ignored, fetchFault is tied 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imemReq, imemAddr         fetch request and word-aligned address
//   imemReady                 memory accepts the request this cycle
//   imemRespValid, imemRdata  in-order response, cannot be stalled
//   redirectValid/Target      PC redirect from execute
//   instructionValid/Ready    handshake towards decoder
//   instructionCode/Pc        fetched word and the address it came from
//   fetchFault                misaligned-redirect trap indication

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRdata,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        instructionValid,
    input  logic        instructionReady,
    output logic [31:0] instructionCode,
    output logic [31:0] instructionPc,
    output logic        fetchFault
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        outValid_q, outValid_d;
    logic [31:0] outCode_q, outCode_d;
    logic [31:0] outPc_q, outPc_d;
    logic [31:0] skidCode_q, skidCode_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic        dropPending_q, dropPending_d;

    logic        accepted;
    logic        consume;
    logic        inFlight;
    logic [31:0] target;

    // The request is masked while reset is held so the stage is silent until
    // the first cycle after release.
    assign imemReq          = (state_q == REQ) && !rst;
    assign imemAddr         = pc_q;
    assign instructionValid = outValid_q;
    assign instructionCode  = outCode_q;
    assign instructionPc    = outPc_q;

    assign accepted = imemReq && imemReady;
    assign consume  = outValid_q && instructionReady;
    // A response is still owed by memory either in WAIT or, after a
    // misaligned redirect, while parked in FAULT with a drop pending.
    assign inFlight = (state_q == WAIT) || dropPending_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign target     = redirectTarget;
    assign misaligned = (redirectTarget[1:0] != 2'b00);
    assign fetchFault = (state_q == FAULT);
`else
    assign target     = redirectTarget & 32'hFFFF_FFFC;
    assign fetchFault = 1'b0;
`endif

    // Next-state logic. A redirect overrides everything else: the output and
    // skid are flushed, and any response still owed by memory is marked for
    // discard so that only one request is ever outstanding.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outValid_d    = outValid_q;
        outCode_d     = outCode_q;
        outPc_d       = outPc_q;
        skidCode_d    = skidCode_q;
        skidPc_d      = skidPc_q;
        dropPending_d = dropPending_q;

        if (redirectValid) begin
            outValid_d    = 1'b0;
            outCode_d     = 32'h0;
            outPc_d       = 32'h0;
            skidCode_d    = 32'h0;
            skidPc_d      = 32'h0;
            pc_d          = target;
            // A response arriving this same cycle is the owed one and is
            // simply dropped now, so nothing remains to discard later.
            dropPending_d = (inFlight && !imemRespValid) || accepted;
            state_d       = dropPending_d ? WAIT : REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                state_d = FAULT;
            end
`endif
        end else begin
            if (consume) begin
                outValid_d = 1'b0;
            end
            case (state_q)
                REQ: begin
                    if (accepted) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imemRespValid) begin
                        if (dropPending_q) begin
                            dropPending_d = 1'b0;
                            state_d       = REQ;
                        end else begin
                            pc_d = pc_q + 32'd4;
                            if (!outValid_q || consume) begin
                                outValid_d = 1'b1;
                                outCode_d  = imemRdata;
                                outPc_d    = pc_q;
                                state_d    = REQ;
                            end else begin
                                skidCode_d = imemRdata;
                                skidPc_d   = pc_q;
                                state_d    = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        outValid_d = 1'b1;
                        outCode_d  = skidCode_q;
                        outPc_d    = skidPc_q;
                        state_d    = REQ;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                FAULT: begin
                    if (imemRespValid) begin
                        dropPending_d = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // State register with synchronous reset; a reset also forgets any
    // in-flight request, so a late response lands in REQ and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            outValid_q    <= 1'b0;
            outCode_q     <= 32'h0;
            outPc_q       <= 32'h0;
            skidCode_q    <= 32'h0;
            skidPc_q      <= 32'h0;
            dropPending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outValid_q    <= outValid_d;
            outCode_q     <= outCode_d;
            outPc_q       <= outPc_d;
            skidCode_q    <= skidCode_d;
            skidPc_q      <= skidPc_d;
            dropPending_q <= dropPending_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so each check reflects the state left by the preceding rising edge.
// When FETCH_MISALIGN_TRAP_EN is defined the trap path is checked, otherwise
// the bench checks that the low target bits are ignored.

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRespValid;
    logic [31:0] imemRdata;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        instructionValid;
    logic        instructionReady;
    logic [31:0] instructionCode;
    logic [31:0] instructionPc;
    logic        fetchFault;

    int testCount;
    int failCount;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .imemReq          (imemReq),
        .imemAddr         (imemAddr),
        .imemReady        (imemReady),
        .imemRespValid    (imemRespValid),
        .imemRdata        (imemRdata),
        .redirectValid    (redirectValid),
        .redirectTarget   (redirectTarget),
        .instructionValid (instructionValid),
        .instructionReady (instructionReady),
        .instructionCode  (instructionCode),
        .instructionPc    (instructionPc),
        .fetchFault       (fetchFault)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's worth of inputs on the falling edge, then let the
    // combinational outputs settle before any check.
    task automatic applyStimulus(input logic rstIn, input logic readyIn,
                                 input logic respIn, input logic [31:0] dataIn,
                                 input logic redirIn, input logic [31:0] targetIn,
                                 input logic consumeIn);
        @(negedge clk);
        rst              = rstIn;
        imemReady        = readyIn;
        imemRespValid    = respIn;
        imemRdata        = dataIn;
        redirectValid    = redirIn;
        redirectTarget   = targetIn;
        instructionReady = consumeIn;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount        = 0;
        failCount        = 0;
        rst              = 1'b1;
        imemReady        = 1'b0;
        imemRespValid    = 1'b0;
        imemRdata        = 32'h0;
        redirectValid    = 1'b0;
        redirectTarget   = 32'h0;
        instructionReady = 1'b0;

        // Reset values
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("rstReq",   {31'h0, imemReq}, 32'h0);
        checkOutput("rstAddr",  imemAddr, 32'h0);
        checkOutput("rstValid", {31'h0, instructionValid}, 32'h0);
        checkOutput("rstCode",  instructionCode, 32'h0);
        checkOutput("rstPc",    instructionPc, 32'h0);
        checkOutput("rstFault", {31'h0, fetchFault}, 32'h0);

        // Back-to-back fetch, 1-cycle memory, decoder always ready
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("c0Req",  {31'h0, imemReq}, 32'h1);
        checkOutput("c0Addr", imemAddr, 32'h0);
        applyStimulus(0, 1, 1, 32'h002081b3, 0, 32'h0, 1);
        checkOutput("c1Req",   {31'h0, imemReq}, 32'h0);
        checkOutput("c1Valid", {31'h0, instructionValid}, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("w0Valid", {31'h0, instructionValid}, 32'h1);
        checkOutput("w0Code",  instructionCode, 32'h002081b3);
        checkOutput("w0Pc",    instructionPc, 32'h0);
        checkOutput("w0Addr",  imemAddr, 32'h4);
        checkOutput("w0Req",   {31'h0, imemReq}, 32'h1);
        applyStimulus(0, 1, 1, 32'h00508113, 0, 32'h0, 1);
        checkOutput("gapValid", {31'h0, instructionValid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("w1Valid", {31'h0, instructionValid}, 32'h1);
        checkOutput("w1Code",  instructionCode, 32'h00508113);
        checkOutput("w1Pc",    instructionPc, 32'h4);
        checkOutput("w1Addr",  imemAddr, 32'h8);

        // Decoder stall: word 0 held, word 1 parked in skid
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 1, 1, 32'h002081b3, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("stW0Code", instructionCode, 32'h002081b3);
        checkOutput("stReq4",   imemAddr, 32'h4);
        applyStimulus(0, 1, 1, 32'h00508113, 0, 32'h0, 0);
        checkOutput("stHeld0", instructionCode, 32'h002081b3);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("holdReq",   {31'h0, imemReq}, 32'h0);
        checkOutput("holdValid", {31'h0, instructionValid}, 32'h1);
        checkOutput("holdPc",    instructionPc, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("holdReq2",  {31'h0, imemReq}, 32'h0);
        checkOutput("holdCode2", instructionCode, 32'h002081b3);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("holdReq3", {31'h0, imemReq}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("skidValid", {31'h0, instructionValid}, 32'h1);
        checkOutput("skidCode",  instructionCode, 32'h00508113);
        checkOutput("skidPc",    instructionPc, 32'h4);
        checkOutput("skidReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("skidAddr",  imemAddr, 32'h8);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("stableAddr", imemAddr, 32'h8);

        // Redirect to 0x100 while the 0x8 request is outstanding
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h100, 0);
        checkOutput("rdWaitReq", {31'h0, imemReq}, 32'h0);
        applyStimulus(0, 1, 1, 32'hDEADBEEF, 0, 32'h0, 1);
        checkOutput("rdFlushValid", {31'h0, instructionValid}, 32'h0);
        checkOutput("rdDropReq",    {31'h0, imemReq}, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("rdNoPc8",   {31'h0, instructionValid}, 32'h0);
        checkOutput("rdReq",     {31'h0, imemReq}, 32'h1);
        checkOutput("rdAddr",    imemAddr, 32'h100);
        applyStimulus(0, 1, 1, 32'h00000013, 0, 32'h0, 0);
        checkOutput("rdWait2", {31'h0, instructionValid}, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("tgtCode", instructionCode, 32'h00000013);
        checkOutput("tgtPc",   instructionPc, 32'h100);
        checkOutput("tgtAddr", imemAddr, 32'h104);

        // Redirect coinciding with consume and response
        applyStimulus(0, 0, 1, 32'hBADC0DE0, 1, 32'h200, 1);
        checkOutput("triValidPre", {31'h0, instructionValid}, 32'h1);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("triValid", {31'h0, instructionValid}, 32'h0);
        checkOutput("triReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("triAddr",  imemAddr, 32'h200);
        applyStimulus(0, 0, 1, 32'h00100093, 0, 32'h0, 1);
        checkOutput("triWaitReq", {31'h0, imemReq}, 32'h0);

        // Wrap from 0xFFFF_FFFC, redirect from REQ with nothing outstanding
        applyStimulus(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        checkOutput("triCode", instructionCode, 32'h00100093);
        checkOutput("triPc",   instructionPc, 32'h200);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("wrapFlush", {31'h0, instructionValid}, 32'h0);
        checkOutput("wrapReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("wrapAddr",  imemAddr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 1, 32'hAAAA5555, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h102, 0);
        checkOutput("wrapPc",    instructionPc, 32'hFFFF_FFFC);
        checkOutput("wrapCode",  instructionCode, 32'hAAAA5555);
        checkOutput("wrapNext",  imemAddr, 32'h0);

        // Misaligned redirect to 0x102, then aligned redirect to 0x200
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("misValid", {31'h0, instructionValid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misFault", {31'h0, fetchFault}, 32'h1);
        checkOutput("misReq",   {31'h0, imemReq}, 32'h0);
`else
        checkOutput("misFault", {31'h0, fetchFault}, 32'h0);
        checkOutput("misReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("misAddr",  imemAddr, 32'h100);
`endif
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h200, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misFaultHeld", {31'h0, fetchFault}, 32'h1);
`else
        checkOutput("misAddrHeld", imemAddr, 32'h100);
`endif
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("clrFault", {31'h0, fetchFault}, 32'h0);
        checkOutput("clrReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("clrAddr",  imemAddr, 32'h200);

        // Reset while a request is in flight; the late response is ignored
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("midRstReq", {31'h0, imemReq}, 32'h0);
        applyStimulus(0, 0, 1, 32'h12345678, 0, 32'h0, 1);
        checkOutput("postRstReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("postRstAddr",  imemAddr, 32'h0);
        checkOutput("postRstValid", {31'h0, instructionValid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("lateRespValid", {31'h0, instructionValid}, 32'h0);
        checkOutput("lateRespReq",   {31'h0, imemReq}, 32'h1);
        checkOutput("lateRespAddr",  imemAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
